stage4: RTL and testbench

Memory-access stage of the RV32I pipeline; it consumes the execute-stage pipeline registers (instruction, ALU result/effective address, store data, CSR write data). Loads and stores run over a req/ack data-memory handshake, with byte-lane steering for stores and sign/zero extension for loads. While an access is outstanding the stage stalls the front of the pipeline through `halt_o`. Results are registered toward writeback.

---
 rtl/stage4.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_stage4.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage4.sv
// ---------------------------------------------------------------------------
// stage4 -- memory-access stage of the RV32I pipeline.
//
// Takes the execute-stage pipeline registers, runs loads and stores over a
// req/ack data-memory handshake (byte-lane steering for stores, sign/zero
// extension for loads), stalls the front of the pipeline while an access is
// outstanding, and registers the result toward writeback.
//
// Optional feature macro: STAGE4_TIMEOUT_EN
//    When defined, an access that waits TIMEOUT_CYCLES cycles without an ack
//    is aborted, bus_err_o pulses and a NOP is written back. When undefined
//    the stage waits for an ack indefinitely and bus_err_o is tied low.
//
// Parameters
//    TIMEOUT_CYCLES  wait-state limit (only used with STAGE4_TIMEOUT_EN)
//
// Ports
//    clk           clock, all state updates on the rising edge
//    reset         synchronous, active-high reset
//    instr_3       instruction from execute
//    data_3        ALU result / effective address
//    data2_3       rs2 value (store data)
//    csrData_3     CSR write data, passed through
//    dmem_req      access request (combinational)
//    dmem_we       1 = store, 0 = load
//    dmem_addr     word-aligned access address
//    dmem_be       byte enables
//    dmem_wdata    lane-steered store data
//    dmem_ack      access complete, dmem_rdata valid in the same cycle
//    dmem_rdata    read word
//    halt_o        stall request to stages 1-3 (combinational)
//    misalign_o    one-cycle pulse on a misaligned access
//    bus_err_o     one-cycle pulse on an access timeout
//    instr_o_ff    registered instruction to writeback
//    wbData_o_ff   registered writeback data
//    csrData_o_ff  registered CSR data
// ---------------------------------------------------------------------------
module stage4 #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_3,
   input  logic [31:0] data_3,
   input  logic [31:0] data2_3,
   input  logic [31:0] csrData_3,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        halt_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic [31:0] instr_o_ff,
   output logic [31:0] wbData_o_ff,
   output logic [31:0] csrData_o_ff
);

   localparam logic [31:0] NopInstr = 32'h00000033;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   // A zero or negative wait limit would abort every access immediately.
   if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
      $error("stage4: TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic [4:0]  opcode;
   logic [2:0]  funct3;
   logic        isLoad;
   logic        isStore;
   logic        memOp;
   logic        addrBad;
   logic        misaligned;
   logic        accessGo;
   logic        complete;
   logic        busErr;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadData;
   logic [31:0] instrOut_q, instrOut_d;
   logic [31:0] wbData_q, wbData_d;
   logic [31:0] csrData_q, csrData_d;

`ifdef STAGE4_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] waitCnt_q, waitCnt_d;
`endif

   assign opcode = instr_3[6:2];
   assign funct3 = instr_3[14:12];

   // Memory op decode. Reserved funct3 encodings are not treated as memory
   // ops, so they flow through like any other instruction instead of
   // issuing an access with undefined lanes.
   always_comb begin
      isLoad  = 1'b0;
      isStore = 1'b0;
      if (opcode == 5'b00000) begin
         isLoad = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010)
               || (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      if (opcode == 5'b01000) begin
         isStore = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
   end

   assign memOp = isLoad | isStore;

   // Alignment depends only on the access size held in funct3[1:0].
   always_comb begin
      addrBad = 1'b0;
      case (funct3[1:0])
         2'b01:   addrBad = data_3[0];
         2'b10:   addrBad = |data_3[1:0];
         default: addrBad = 1'b0;
      endcase
   end

   assign misaligned = memOp & addrBad;
   assign accessGo   = memOp & ~addrBad;

   assign dmem_we   = isStore;
   assign dmem_addr = {data_3[31:2], 2'b00};

   // Store lane steering: the data is replicated across the word so the
   // memory only has to honour the byte enables. Loads read the full word.
   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = data2_3;
      if (isStore) begin
         case (funct3[1:0])
            2'b00: begin
               dmem_be    = 4'b0001 << data_3[1:0];
               dmem_wdata = {4{data2_3[7:0]}};
            end
            2'b01: begin
               dmem_be    = data_3[1] ? 4'b1100 : 4'b0011;
               dmem_wdata = {2{data2_3[15:0]}};
            end
            default: begin
               dmem_be    = 4'b1111;
               dmem_wdata = data2_3;
            end
         endcase
      end
   end

   // Load lane selection and sign/zero extension.
   always_comb begin
      loadByte = dmem_rdata[7:0];
      case (data_3[1:0])
         2'b00:   loadByte = dmem_rdata[7:0];
         2'b01:   loadByte = dmem_rdata[15:8];
         2'b10:   loadByte = dmem_rdata[23:16];
         default: loadByte = dmem_rdata[31:24];
      endcase
      loadHalf = data_3[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      loadData = dmem_rdata;
      case (funct3)
         3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
         3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
         3'b100:  loadData = {24'h000000, loadByte};
         3'b101:  loadData = {16'h0000, loadHalf};
         default: loadData = dmem_rdata;
      endcase
   end

   // Access FSM. Request and halt are combinational so a zero-wait access
   // completes in the cycle it is presented. In WAIT the upstream stages are
   // frozen, so the request fields stay stable without extra holding
   // registers. Everything is forced quiet while reset is high.
   always_comb begin
      state_d    = state_q;
      dmem_req   = 1'b0;
      halt_o     = 1'b0;
      misalign_o = 1'b0;
      complete   = 1'b0;
      busErr     = 1'b0;
`ifdef STAGE4_TIMEOUT_EN
      waitCnt_d  = '0;
`endif
      if (!reset) begin
         case (state_q)
            ST_IDLE: begin
               if (misaligned) begin
                  misalign_o = 1'b1;
               end else if (accessGo) begin
                  dmem_req = 1'b1;
                  if (dmem_ack) begin
                     complete = 1'b1;
                  end else begin
                     halt_o  = 1'b1;
                     state_d = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               dmem_req = 1'b1;
               if (dmem_ack) begin
                  complete = 1'b1;
                  state_d  = ST_IDLE;
               end
`ifdef STAGE4_TIMEOUT_EN
               else if (waitCnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                  // Last allowed wait cycle with no ack: abandon the access.
                  busErr  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  halt_o    = 1'b1;
                  waitCnt_d = waitCnt_q + 1'b1;
               end
`else
               else begin
                  halt_o = 1'b1;
               end
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign bus_err_o = busErr;

   // Writeback register next-state. Stalls, aborted accesses and misaligned
   // accesses all emit a bubble and leave the data registers alone. Every
   // other cycle is either a completed access or a non-memory op; stores
   // forward the address like a non-memory op.
   always_comb begin
      instrOut_d = instrOut_q;
      wbData_d   = wbData_q;
      csrData_d  = csrData_q;
      if (halt_o || busErr || misalign_o) begin
         instrOut_d = NopInstr;
      end else begin
         instrOut_d = instr_3;
         wbData_d   = (complete && isLoad) ? loadData : data_3;
         csrData_d  = csrData_3;
      end
   end

   // State and pipeline registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         instrOut_q <= NopInstr;
         wbData_q   <= 32'h0;
         csrData_q  <= 32'h0;
      end else begin
         state_q    <= state_d;
         instrOut_q <= instrOut_d;
         wbData_q   <= wbData_d;
         csrData_q  <= csrData_d;
      end
   end

`ifdef STAGE4_TIMEOUT_EN
   // Wait-cycle counter; only counts while sitting in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         waitCnt_q <= '0;
      end else begin
         waitCnt_q <= waitCnt_d;
      end
   end
`endif

   assign instr_o_ff   = instrOut_q;
   assign wbData_o_ff  = wbData_q;
   assign csrData_o_ff = csrData_q;

endmodule

// File: tb/tb_stage4.sv
// ---------------------------------------------------------------------------
// tb_stage4 -- self-checking bench for stage4.
// Directed vector table, a randomized run against a byte-level reference
// model, and hand-written sequences for reset during a wait and (when
// STAGE4_TIMEOUT_EN is defined) the access timeout.
// ---------------------------------------------------------------------------
module tb_stage4;

   localparam logic [31:0] NOP = 32'h00000033;

   logic        clk;
   logic        reset;
   logic [31:0] instr_3, data_3, data2_3, csrData_3;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        halt_o, misalign_o, bus_err_o;
   logic [31:0] instr_o_ff, wbData_o_ff, csrData_o_ff;

   int total = 0;
   int bad   = 0;

   stage4 #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_3      (instr_3),
      .data_3       (data_3),
      .data2_3      (data2_3),
      .csrData_3    (csrData_3),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .halt_o       (halt_o),
      .misalign_o   (misalign_o),
      .bus_err_o    (bus_err_o),
      .instr_o_ff   (instr_o_ff),
      .wbData_o_ff  (wbData_o_ff),
      .csrData_o_ff (csrData_o_ff)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare a word and log any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare a single bit and log any difference.
   task automatic checkBit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Present one instruction, hold it through 'waits' wait states, then
   // check what was registered toward writeback.
   task automatic applyStimulus(
      input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] data2,
      input logic [31:0] csr, input logic [31:0] rdata, input int waits,
      input logic expReq, input logic expWe, input logic [3:0] expBe,
      input logic [31:0] expWdata, input logic expMis,
      input logic [31:0] expInstr, input logic [31:0] expWb, input logic [31:0] expCsr);
      @(negedge clk);
      instr_3    = instr;
      data_3     = addr;
      data2_3    = data2;
      csrData_3  = csr;
      dmem_rdata = rdata;
      dmem_ack   = expReq && (waits == 0);
      #1;
      checkBit("req", dmem_req, expReq);
      checkBit("halt", halt_o, expReq && (waits > 0));
      checkBit("misalign", misalign_o, expMis);
      if (expReq) begin
         checkOutput("addr", dmem_addr, {addr[31:2], 2'b00});
         checkOutput("be", {28'h0, dmem_be}, {28'h0, expBe});
         checkBit("we", dmem_we, expWe);
         if (expWe) checkOutput("wdata", dmem_wdata, expWdata);
      end
      for (int w = 1; w <= waits; w++) begin
         @(posedge clk);
         #1;
         checkOutput("bubble", instr_o_ff, NOP);
         @(negedge clk);
         dmem_ack = (w == waits);
         #1;
         checkBit("waitReq", dmem_req, 1'b1);
         checkBit("waitHalt", halt_o, w != waits);
         checkOutput("waitBe", {28'h0, dmem_be}, {28'h0, expBe});
      end
      @(posedge clk);
      #1;
      checkOutput("instrOut", instr_o_ff, expInstr);
      checkOutput("wbData", wbData_o_ff, expWb);
      checkOutput("csrData", csrData_o_ff, expCsr);
      dmem_ack = 1'b0;
   endtask

   // Reference model: works from access size in bytes and plain shifts.
   function automatic void refModel(
      input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] data2,
      input logic [31:0] rdata,
      output logic isLd, output logic req, output logic we, output logic [3:0] be,
      output logic [31:0] wdata, output logic mis, output logic [31:0] ldVal);
      logic [4:0]  op;
      logic [2:0]  f3;
      logic        isSt;
      int          size;
      logic [31:0] mask;
      logic [31:0] shifted;
      op    = instr[6:2];
      f3    = instr[14:12];
      isLd  = (op == 5'd0) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      isSt  = (op == 5'd8) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      size  = 1 << f3[1:0];
      mis   = (isLd || isSt) && ((addr % size) != 0);
      req   = (isLd || isSt) && !mis;
      we    = isSt;
      be    = isLd ? 4'hF : 4'(((1 << size) - 1) << addr[1:0]);
      wdata = 32'h0;
      for (int i = 0; i < 4; i++) wdata[8*i +: 8] = 8'(data2 >> (8 * (i % size)));
      mask    = (size == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * size)) - 32'h1);
      shifted = rdata >> (8 * addr[1:0]);
      ldVal   = shifted & mask;
      if (!f3[2] && size < 4 && ldVal[8*size-1]) ldVal = ldVal | ~mask;
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic [31:0] data2;
      logic [31:0] csr;
      logic [31:0] rdata;
      int          waits;
      logic        expReq;
      logic        expWe;
      logic [3:0]  expBe;
      logic [31:0] expWdata;
      logic        expMis;
      logic [31:0] expInstr;
      logic [31:0] expWb;
      logic [31:0] expCsr;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] prevWb, prevCsr, r, r2, instr, addr, data2, csr, rdata;
      logic [31:0] ldVal, wdata, expInstr, expWb, expCsr;
      logic        isLd, req, we, mis;
      logic [3:0]  be;
      logic [2:0]  f3;
      logic [6:0]  opc;
      int          kind, waits;
      int          loadF3[5];
      int          storeF3[3];
      loadF3  = '{0, 1, 2, 4, 5};
      storeF3 = '{0, 1, 2};

      //          instr          addr          data2         csr     rdata         w  rq we be    wdata         ms instrOut      wb            csr
      vecs[0]  = '{32'h00002283, 32'h00000100, 32'h0,        32'hC0, 32'hDEADBEEF, 0, 1, 0, 4'hF, 32'h0,        0, 32'h00002283, 32'hDEADBEEF, 32'hC0};
      vecs[1]  = '{32'h00000283, 32'h00000103, 32'h0,        32'hC1, 32'h80123456, 2, 1, 0, 4'hF, 32'h0,        0, 32'h00000283, 32'hFFFFFF80, 32'hC1};
      vecs[2]  = '{32'h00004283, 32'h00000103, 32'h0,        32'hC2, 32'h80123456, 2, 1, 0, 4'hF, 32'h0,        0, 32'h00004283, 32'h00000080, 32'hC2};
      vecs[3]  = '{32'h00001023, 32'h00000202, 32'h00001234, 32'hC3, 32'h0,        0, 1, 1, 4'hC, 32'h12341234, 0, 32'h00001023, 32'h00000202, 32'hC3};
      vecs[4]  = '{32'h00000023, 32'h00000301, 32'h000000AB, 32'hC4, 32'h0,        1, 1, 1, 4'h2, 32'hABABABAB, 0, 32'h00000023, 32'h00000301, 32'hC4};
      vecs[5]  = '{32'h00002283, 32'h00000102, 32'h0,        32'hC5, 32'h0,        0, 0, 0, 4'h0, 32'h0,        1, NOP,          32'h00000301, 32'hC4};
      vecs[6]  = '{32'h00001283, 32'h00000102, 32'h0,        32'hC6, 32'h80017FFF, 1, 1, 0, 4'hF, 32'h0,        0, 32'h00001283, 32'hFFFF8001, 32'hC6};
      vecs[7]  = '{32'h00005283, 32'h00000102, 32'h0,        32'hC7, 32'h80017FFF, 0, 1, 0, 4'hF, 32'h0,        0, 32'h00005283, 32'h00008001, 32'hC7};
      vecs[8]  = '{32'h00002023, 32'h00000400, 32'hCAFEF00D, 32'hC8, 32'h0,        3, 1, 1, 4'hF, 32'hCAFEF00D, 0, 32'h00002023, 32'h00000400, 32'hC8};
      vecs[9]  = '{32'h00500093, 32'h12345678, 32'h0,        32'hC9, 32'h0,        0, 0, 0, 4'h0, 32'h0,        0, 32'h00500093, 32'h12345678, 32'hC9};
      vecs[10] = '{32'h00001023, 32'h00000201, 32'h00005555, 32'hCA, 32'h0,        0, 0, 0, 4'h0, 32'h0,        1, NOP,          32'h12345678, 32'hC9};
      vecs[11] = '{32'h00000283, 32'h00000101, 32'h0,        32'hCB, 32'h00007F00, 0, 1, 0, 4'hF, 32'h0,        0, 32'h00000283, 32'h0000007F, 32'hCB};

      // Reset state, with an aligned load presented to prove the request is
      // suppressed while reset is high.
      reset      = 1'b1;
      instr_3    = 32'h00002283;
      data_3     = 32'h00000100;
      data2_3    = 32'h0;
      csrData_3  = 32'h0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rstInstr", instr_o_ff, NOP);
      checkOutput("rstWb", wbData_o_ff, 32'h0);
      checkOutput("rstCsr", csrData_o_ff, 32'h0);
      checkBit("rstReq", dmem_req, 1'b0);
      checkBit("rstHalt", halt_o, 1'b0);
      checkBit("rstMis", misalign_o, 1'b0);
      checkBit("rstBusErr", bus_err_o, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].instr, vecs[i].addr, vecs[i].data2, vecs[i].csr,
                       vecs[i].rdata, vecs[i].waits, vecs[i].expReq, vecs[i].expWe,
                       vecs[i].expBe, vecs[i].expWdata, vecs[i].expMis,
                       vecs[i].expInstr, vecs[i].expWb, vecs[i].expCsr);
      end

      $display("[TB] randomized run against reference model");
      prevWb  = 32'h0000007F;
      prevCsr = 32'hCB;
      for (int n = 0; n < 150; n++) begin
         r    = $urandom();
         r2   = $urandom();
         kind = $urandom_range(0, 8);
         if (kind < 5) begin
            f3  = 3'(loadF3[kind]);
            opc = 7'b0000011;
         end else if (kind < 8) begin
            f3  = 3'(storeF3[kind - 5]);
            opc = 7'b0100011;
         end else begin
            f3  = r[14:12];
            opc = 7'b0010011;
         end
         instr = {r[31:15], f3, r[11:7], opc};
         addr  = r2 & 32'h00000FFF;
         data2 = $urandom();
         csr   = $urandom();
         rdata = $urandom();
         refModel(instr, addr, data2, rdata, isLd, req, we, be, wdata, mis, ldVal);
         waits = req ? $urandom_range(0, 3) : 0;
         if (mis) begin
            expInstr = NOP;
            expWb    = prevWb;
            expCsr   = prevCsr;
         end else begin
            expInstr = instr;
            expWb    = isLd ? ldVal : addr;
            expCsr   = csr;
         end
         applyStimulus(instr, addr, data2, csr, rdata, waits, req, we, be, wdata,
                       mis, expInstr, expWb, expCsr);
         prevWb  = expWb;
         prevCsr = expCsr;
      end

      $display("[TB] reset during wait");
      @(negedge clk);
      instr_3   = 32'h00002283;
      data_3    = 32'h00000100;
      csrData_3 = 32'h77;
      dmem_ack  = 1'b0;
      #1;
      checkBit("rmwHalt0", halt_o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      #1;
      checkBit("rmwReq1", dmem_req, 1'b1);
      checkBit("rmwHalt1", halt_o, 1'b1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkBit("rmwReqRst", dmem_req, 1'b0);
      checkBit("rmwHaltRst", halt_o, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("rmwInstr", instr_o_ff, NOP);
      checkOutput("rmwWb", wbData_o_ff, 32'h0);
      @(negedge clk);
      reset     = 1'b0;
      instr_3   = 32'h00100093;
      data_3    = 32'h00000055;
      csrData_3 = 32'h00000066;
      dmem_ack  = 1'b1;
      #1;
      checkBit("lateAckReq", dmem_req, 1'b0);
      checkBit("lateAckHalt", halt_o, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("lateAckInstr", instr_o_ff, 32'h00100093);
      checkOutput("lateAckWb", wbData_o_ff, 32'h00000055);
      checkOutput("lateAckCsr", csrData_o_ff, 32'h00000066);
      dmem_ack = 1'b0;

`ifdef STAGE4_TIMEOUT_EN
      $display("[TB] access timeout");
      @(negedge clk);
      instr_3   = 32'h00002283;
      data_3    = 32'h00000100;
      csrData_3 = 32'h88;
      dmem_ack  = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checkBit("toHalt", halt_o, k < 4);
         checkBit("toBusErr", bus_err_o, k == 4);
         @(posedge clk);
         #1;
         checkOutput("toInstr", instr_o_ff, NOP);
      end
      @(negedge clk);
      instr_3 = 32'h00100093;
      #1;
      checkBit("toIdleReq", dmem_req, 1'b0);
      checkBit("toBusErrDone", bus_err_o, 1'b0);
      @(posedge clk);
      #1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
